// File: rtl/bus_arbiter_if.sv
// Signal bundle between the two bus masters, the arbiter and the system bus.
// The arbiter takes the slave view; the masters/bus side takes the master view.
interface bus_arbiter_if;
  logic        m0Req;
  logic        m0Write;
  logic [31:0] m0Address;
  logic [31:0] m0DataOut;
  logic [31:0] m0DataIn;
  logic        m0Done;

  logic        m1Req;
  logic        m1Write;
  logic [31:0] m1Address;
  logic [31:0] m1DataOut;
  logic [31:0] m1DataIn;
  logic        m1Done;

  logic [31:0] busAddress;
  logic [31:0] busDataOut;
  logic        busWriteEnable;
  logic [31:0] busDataIn;

  logic        busy;
  logic        grantId;

  modport slave (
    input  m0Req, m0Write, m0Address, m0DataOut,
    input  m1Req, m1Write, m1Address, m1DataOut,
    input  busDataIn,
    output m0DataIn, m0Done, m1DataIn, m1Done,
    output busAddress, busDataOut, busWriteEnable,
    output busy, grantId
  );

  modport master (
    output m0Req, m0Write, m0Address, m0DataOut,
    output m1Req, m1Write, m1Address, m1DataOut,
    output busDataIn,
    input  m0DataIn, m0Done, m1DataIn, m1Done,
    input  busAddress, busDataOut, busWriteEnable,
    input  busy, grantId
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter that owns the system bus for MEM_LATENCY
// cycles per transaction and returns read data plus a one-cycle done pulse.
module bus_arbiter #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_id_q, grant_id_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] m0_din_q, m0_din_d;
  logic [31:0] m1_din_q, m1_din_d;
  logic        m0_done_q, m0_done_d;
  logic        m1_done_q, m1_done_d;
  logic        busy_q, busy_d;
  logic        sel;

  // NOTE: every signal written here gets its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    m0_din_d     = m0_din_q;
    m1_din_d     = m1_din_q;
    m0_done_d    = 1'b0;
    m1_done_d    = 1'b0;
    sel          = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.m0Req || bus.m1Req) begin
          // On a tie the master that did not own the bus last time wins.
          sel          = (bus.m0Req && bus.m1Req) ? ~last_grant_q : bus.m1Req;
          addr_d       = sel ? bus.m1Address : bus.m0Address;
          wdata_d      = sel ? bus.m1DataOut : bus.m0DataOut;
          we_d         = sel ? bus.m1Write   : bus.m0Write;
          grant_id_d   = sel;
          last_grant_d = sel;
          cnt_d        = CNT_INIT;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (grant_id_q) m1_din_d = bus.busDataIn;
            else            m0_din_d = bus.busDataIn;
          end
          m0_done_d = ~grant_id_q;
          m1_done_d = grant_id_q;
          we_d      = 1'b0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      we_q         <= 1'b0;
      m0_din_q     <= 32'd0;
      m1_din_q     <= 32'd0;
      m0_done_q    <= 1'b0;
      m1_done_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      m0_din_q     <= m0_din_d;
      m1_din_q     <= m1_din_d;
      m0_done_q    <= m0_done_d;
      m1_done_q    <= m1_done_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.busAddress     = addr_q;
  assign bus.busDataOut     = wdata_q;
  assign bus.busWriteEnable = we_q;
  assign bus.m0DataIn       = m0_din_q;
  assign bus.m1DataIn       = m1_din_q;
  assign bus.m0Done         = m0_done_q;
  assign bus.m1Done         = m1_done_q;
  assign bus.busy           = busy_q;
  assign bus.grantId        = grant_id_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: one instance at latency 1, one at latency 3,
// with a scoreboard of expected done pulses for the latency-3 instance.
module tb_bus_arbiter;

  localparam logic [31:0] KEY = 32'h5A5A_0F0F;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;

  always #5 clk = ~clk;

  bus_arbiter_if if1 ();
  bus_arbiter_if if3 ();

  bus_arbiter #(.MEM_LATENCY(1)) u_dut1 (.clk(clk), .reset(rst1), .bus(if1.slave));
  bus_arbiter #(.MEM_LATENCY(3)) u_dut3 (.clk(clk), .reset(rst3), .bus(if3.slave));

  // Memory model for the latency-3 bus: read data is derived from the address.
  assign if3.busDataIn = if3.busAddress ^ KEY;

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          done_seen = 0;
  int          we_cycles = 0;
  int          done_cycles[$];
  exp_t        sb[$];
  logic [31:0] exp_din[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle of the latency-3 bus: count write cycles, score done pulses.
  task automatic step3();
    logic        owner;
    exp_t        e;
    logic [31:0] own_din;
    logic [31:0] oth_din;
    @(negedge clk);
    cycle++;
    if (if3.busWriteEnable) we_cycles++;
    if (if3.m0Done || if3.m1Done) begin
      owner = if3.m1Done;
      done_seen++;
      done_cycles.push_back(cycle);
      check("single_done", 32'(if3.m0Done & if3.m1Done), 32'd0);
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e       = sb.pop_front();
        own_din = owner ? if3.m1DataIn : if3.m0DataIn;
        oth_din = owner ? if3.m0DataIn : if3.m1DataIn;
        check("done_owner", 32'(owner), 32'(e.id));
        check("grantId", 32'(if3.grantId), 32'(e.id));
        check("owner_datain", own_din, e.data);
        check("other_datain", oth_din, exp_din[!owner]);
        check("we_at_done", 32'(if3.busWriteEnable), 32'd0);
        exp_din[owner] = e.data;
      end
    end
  endtask

  task automatic wait_done(input int budget);
    int start;
    int n;
    start = done_seen;
    n = 0;
    while (done_seen == start && n < budget) begin
      step3();
      n++;
    end
    check("done_within_budget", 32'(done_seen != start), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int w0;

    rst1 = 1'b1;
    rst3 = 1'b1;
    if1.m0Req = 0; if1.m0Write = 0; if1.m0Address = 0; if1.m0DataOut = 0;
    if1.m1Req = 0; if1.m1Write = 0; if1.m1Address = 0; if1.m1DataOut = 0;
    if1.busDataIn = 0;
    if3.m0Req = 0; if3.m0Write = 0; if3.m0Address = 0; if3.m0DataOut = 0;
    if3.m1Req = 0; if3.m1Write = 0; if3.m1Address = 0; if3.m1DataOut = 0;
    exp_din[0] = 0;
    exp_din[1] = 0;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(if3.busy), 32'd0);
    check("rst_grantId", 32'(if3.grantId), 32'd0);
    check("rst_busAddress", if3.busAddress, 32'd0);
    check("rst_busDataOut", if3.busDataOut, 32'd0);
    check("rst_busWE", 32'(if3.busWriteEnable), 32'd0);
    check("rst_m0DataIn", if3.m0DataIn, 32'd0);
    check("rst_m1DataIn", if3.m1DataIn, 32'd0);
    check("rst_dones", 32'({if3.m0Done, if3.m1Done}), 32'd0);
    check("rst1_busy", 32'(if1.busy), 32'd0);

    // Single read at latency 1, request raised together with reset release.
    if1.m0Address = 32'h100;
    if1.busDataIn = 32'hDEADBEEF;
    if1.m0Req     = 1'b1;
    rst1 = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);
    check("a_busAddress", if1.busAddress, 32'h100);
    check("a_busy_c1", 32'(if1.busy), 32'd1);
    check("a_done_c1", 32'(if1.m0Done), 32'd0);
    if1.m0Req = 1'b0;
    @(negedge clk);
    check("a_done_c2", 32'(if1.m0Done), 32'd1);
    check("a_m0DataIn", if1.m0DataIn, 32'hDEADBEEF);
    check("a_busy_c2", 32'(if1.busy), 32'd1);
    check("a_m1Done", 32'(if1.m1Done), 32'd0);
    @(negedge clk);
    check("a_done_c3", 32'(if1.m0Done), 32'd0);
    check("a_busy_c3", 32'(if1.busy), 32'd0);
    check("a_m0DataIn_held", if1.m0DataIn, 32'hDEADBEEF);
    @(negedge clk);
    check("a_busy_c4", 32'(if1.busy), 32'd0);

    // Single write on master 1 at latency 3.
    if3.m1Address = 32'h20;
    if3.m1DataOut = 32'h12345678;
    if3.m1Write   = 1'b1;
    if3.m1Req     = 1'b1;
    sb.push_back('{1'b1, exp_din[1]});
    w0 = we_cycles;
    d0 = done_seen;
    step3();
    check("b_busAddress", if3.busAddress, 32'h20);
    check("b_busDataOut", if3.busDataOut, 32'h12345678);
    check("b_busWE", 32'(if3.busWriteEnable), 32'd1);
    if3.m1Req = 1'b0;
    repeat (5) step3();
    check("b_we_cycles", 32'(we_cycles - w0), 32'd3);
    check("b_done_count", 32'(done_seen - d0), 32'd1);
    check("b_m1DataIn", if3.m1DataIn, 32'd0);
    check("b_busy", 32'(if3.busy), 32'd0);

    // Simultaneous requests after reset: grants alternate starting with m0.
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    exp_din[0] = 0;
    exp_din[1] = 0;
    if3.m1Write   = 1'b0;
    if3.m0Write   = 1'b0;
    if3.m0Address = 32'h1000;
    if3.m1Address = 32'h2000;
    for (int i = 0; i < 4; i++)
      sb.push_back('{logic'(i % 2), ((i % 2) != 0) ? (32'h2000 ^ KEY) : (32'h1000 ^ KEY)});
    d0 = done_seen;
    if3.m0Req = 1'b1;
    if3.m1Req = 1'b1;
    repeat (4) wait_done(10);
    if3.m0Req = 1'b0;
    if3.m1Req = 1'b0;
    repeat (4) step3();
    check("c_done_count", 32'(done_seen - d0), 32'd4);
    check("c_busy", 32'(if3.busy), 32'd0);

    // m0 back-to-back; m1 raised mid-transaction wins the next IDLE edge.
    done_cycles.delete();
    if3.m0Address = 32'h300;
    repeat (3) sb.push_back('{1'b0, 32'h300 ^ KEY});
    if3.m0Req = 1'b1;
    wait_done(10);
    wait_done(10);
    repeat (3) step3();
    if3.m1Address = 32'h400;
    if3.m1Req     = 1'b1;
    sb.push_back('{1'b1, 32'h400 ^ KEY});
    sb.push_back('{1'b0, 32'h300 ^ KEY});
    wait_done(10);
    wait_done(10);
    if3.m1Req = 1'b0;
    wait_done(10);
    if3.m0Req = 1'b0;
    check("d_done_count", 32'(done_cycles.size()), 32'd5);
    for (int i = 1; i < done_cycles.size(); i++)
      check("d_period", 32'(done_cycles[i] - done_cycles[i-1]), 32'd5);
    repeat (3) step3();
    check("d_busy", 32'(if3.busy), 32'd0);

    // Reset during the second ACCESS cycle of a write.
    if3.m0Write   = 1'b1;
    if3.m0Address = 32'h500;
    if3.m0DataOut = 32'hCAFEF00D;
    if3.m0Req     = 1'b1;
    d0 = done_seen;
    step3();
    step3();
    check("e_we_before", 32'(if3.busWriteEnable), 32'd1);
    #2;
    rst3 = 1'b1;
    if3.m0Req = 1'b0;
    #1;
    check("e_we_async", 32'(if3.busWriteEnable), 32'd0);
    check("e_busy_async", 32'(if3.busy), 32'd0);
    check("e_done_async", 32'({if3.m0Done, if3.m1Done}), 32'd0);
    check("e_busAddress", if3.busAddress, 32'd0);
    exp_din[0] = 0;
    exp_din[1] = 0;
    @(negedge clk);
    rst3 = 1'b0;
    repeat (3) step3();
    check("e_no_done", 32'(done_seen - d0), 32'd0);
    check("e_busy_idle", 32'(if3.busy), 32'd0);
    if3.m0Write   = 1'b0;
    if3.m1Write   = 1'b0;
    if3.m1Address = 32'h600;
    sb.push_back('{1'b1, 32'h600 ^ KEY});
    if3.m1Req = 1'b1;
    step3();
    if3.m1Req = 1'b0;
    wait_done(10);
    check("e_fresh_done", 32'(done_seen - d0), 32'd1);

    // m0Req dropped mid-ACCESS: completes once, no follow-on transaction.
    if3.m0Address = 32'h700;
    sb.push_back('{1'b0, 32'h700 ^ KEY});
    d0 = done_seen;
    if3.m0Req = 1'b1;
    step3();
    step3();
    if3.m0Req = 1'b0;
    wait_done(10);
    repeat (8) step3();
    check("f_done_count", 32'(done_seen - d0), 32'd1);
    check("f_busy", 32'(if3.busy), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
